// File: rtl/xfer_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : xfer_scheduler
//  Description : Pops CDBs from the ifq submission queue, decodes BSM_WRITE /
//                BSM_READ, sequences one xfer_buffer<->tbm transfer per 4 KB
//                block and reports in-progress / done / error status to ifq.
//  Revision    : 1.0  initial release
// ============================================================================
module xfer_scheduler #(
  parameter int BLOCK_SHIFT = 12,
  parameter int MAX_BLOCKS  = 256,
  parameter int TIMEOUT     = 4096,
  parameter int ADDR_W      = 32
) (
  input  logic              clock_fpga,
  input  logic              reset,
  input  logic              sq_select,
  input  logic [255:0]      cmd_out,
  input  logic [7:0]        sq_index,
  output logic              sq_ack,
  output logic              xfer_buf_select,
  output logic              mwrite_enable,
  output logic [ADDR_W-1:0] tbm_address,
  input  logic              xfer_complete,
  output logic              status_update_enable,
  output logic [7:0]        cmdq_index,
  output logic [1:0]        status_code,
  output logic              busy
);

  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_DECODE   = 3'd1;
  localparam logic [2:0] c_ANNOUNCE = 3'd2;
  localparam logic [2:0] c_ISSUE    = 3'd3;
  localparam logic [2:0] c_WAIT     = 3'd4;
  localparam logic [2:0] c_STATUS   = 3'd5;

  localparam logic [7:0]       c_OP_WRITE = 8'h40;
  localparam logic [7:0]       c_OP_READ  = 8'h30;
  localparam logic [1:0]       c_ST_DONE  = 2'b11;
  localparam logic [1:0]       c_ST_ERR   = 2'b10;
  localparam logic [1:0]       c_ST_PROG  = 2'b01;
  localparam logic [15:0]      c_MAX_BLK  = 16'(MAX_BLOCKS);
  localparam logic [TMR_W-1:0] c_TMO_LAST = TMR_W'(TIMEOUT - 1);

  logic [2:0]        r_state, w_state_d;
  logic [7:0]        r_opcode, w_opcode_d;
  logic [31:0]       r_lba, w_lba_d;
  logic [15:0]       r_blocks, w_blocks_d;
  logic [7:0]        r_tag, w_tag_d;
  logic [7:0]        r_slot, w_slot_d;
  logic [15:0]       r_blk_cnt, w_blk_cnt_d;
  logic [TMR_W-1:0]  r_timer, w_timer_d;
  logic [1:0]        r_final, w_final_d;
  logic              r_sq_ack, w_sq_ack_d;
  logic              r_xbs, w_xbs_d;
  logic              r_mwe, w_mwe_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic              r_sue, w_sue_d;
  logic [7:0]        r_cmdq, w_cmdq_d;
  logic [1:0]        r_code, w_code_d;

  logic        w_bad_cmd;
  logic        w_last_blk;
  logic [31:0] w_blk_lba;
  logic [63:0] w_shift;
  logic        w_unused;

  // Command classification and current block address (wraps at ADDR_W bits)
  assign w_bad_cmd  = ((r_opcode != c_OP_WRITE) && (r_opcode != c_OP_READ)) ||
                      (r_blocks > c_MAX_BLK);
  assign w_last_blk = ((r_blk_cnt + 16'd1) == r_blocks);
  assign w_blk_lba  = r_lba + {16'd0, r_blk_cnt};
  assign w_shift    = {32'd0, w_blk_lba} << BLOCK_SHIFT;
  assign w_unused   = ^{cmd_out, r_tag, w_shift};

  // State register
  always_ff @(posedge clock_fpga or negedge reset) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_state_d;
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      c_IDLE:     if (sq_select) w_state_d = c_DECODE;
      c_DECODE:   if (w_bad_cmd || (r_blocks == 16'd0)) w_state_d = c_STATUS;
                  else w_state_d = c_ANNOUNCE;
      c_ANNOUNCE: w_state_d = c_ISSUE;
      c_ISSUE:    w_state_d = c_WAIT;
      c_WAIT:     if (xfer_complete) w_state_d = w_last_blk ? c_STATUS : c_ISSUE;
                  else if (r_timer == c_TMO_LAST) w_state_d = c_STATUS;
      c_STATUS:   w_state_d = c_IDLE;
      default:    w_state_d = c_IDLE;
    endcase
  end

  // Output / datapath next values; outputs are registered so strobes land
  // one cycle after the state that decides them
  always_comb begin
    w_opcode_d  = r_opcode;
    w_lba_d     = r_lba;
    w_blocks_d  = r_blocks;
    w_tag_d     = r_tag;
    w_slot_d    = r_slot;
    w_blk_cnt_d = r_blk_cnt;
    w_timer_d   = r_timer;
    w_final_d   = r_final;
    w_sq_ack_d  = 1'b0;
    w_sue_d     = 1'b0;
    w_xbs_d     = r_xbs;
    w_mwe_d     = r_mwe;
    w_addr_d    = r_addr;
    w_cmdq_d    = r_cmdq;
    w_code_d    = r_code;
    case (r_state)
      c_IDLE: begin
        if (sq_select) begin
          w_opcode_d = cmd_out[7:0];
          w_lba_d    = cmd_out[63:32];
          w_blocks_d = cmd_out[111:96];
          w_tag_d    = cmd_out[127:120];
          w_slot_d   = sq_index;
          w_sq_ack_d = 1'b1;
        end
      end
      c_DECODE: begin
        if (w_bad_cmd)                  w_final_d   = c_ST_ERR;
        else if (r_blocks == 16'd0)     w_final_d   = c_ST_DONE;
        else                            w_blk_cnt_d = 16'd0;
      end
      c_ANNOUNCE: begin
        w_sue_d  = 1'b1;
        w_cmdq_d = r_slot;
        w_code_d = c_ST_PROG;
      end
      c_ISSUE: begin
        w_addr_d  = w_shift[ADDR_W-1:0];
        w_mwe_d   = (r_opcode == c_OP_WRITE);
        w_xbs_d   = 1'b1;
        w_timer_d = '0;
      end
      c_WAIT: begin
        if (xfer_complete) begin
          w_xbs_d     = 1'b0;
          w_blk_cnt_d = r_blk_cnt + 16'd1;
          if (w_last_blk) w_final_d = c_ST_DONE;
        end else if (r_timer == c_TMO_LAST) begin
          w_xbs_d   = 1'b0;
          w_final_d = c_ST_ERR;
        end else begin
          w_timer_d = r_timer + 1'b1;
        end
      end
      c_STATUS: begin
        w_sue_d  = 1'b1;
        w_cmdq_d = r_slot;
        w_code_d = r_final;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock_fpga or negedge reset) begin
    if (!reset) begin
      r_opcode  <= '0;
      r_lba     <= '0;
      r_blocks  <= '0;
      r_tag     <= '0;
      r_slot    <= '0;
      r_blk_cnt <= '0;
      r_timer   <= '0;
      r_final   <= '0;
      r_sq_ack  <= 1'b0;
      r_sue     <= 1'b0;
      r_xbs     <= 1'b0;
      r_mwe     <= 1'b0;
      r_addr    <= '0;
      r_cmdq    <= '0;
      r_code    <= '0;
    end else begin
      r_opcode  <= w_opcode_d;
      r_lba     <= w_lba_d;
      r_blocks  <= w_blocks_d;
      r_tag     <= w_tag_d;
      r_slot    <= w_slot_d;
      r_blk_cnt <= w_blk_cnt_d;
      r_timer   <= w_timer_d;
      r_final   <= w_final_d;
      r_sq_ack  <= w_sq_ack_d;
      r_sue     <= w_sue_d;
      r_xbs     <= w_xbs_d;
      r_mwe     <= w_mwe_d;
      r_addr    <= w_addr_d;
      r_cmdq    <= w_cmdq_d;
      r_code    <= w_code_d;
    end
  end

  assign sq_ack               = r_sq_ack;
  assign xfer_buf_select      = r_xbs;
  assign mwrite_enable        = r_mwe;
  assign tbm_address          = r_addr;
  assign status_update_enable = r_sue;
  assign cmdq_index           = r_cmdq;
  assign status_code          = r_code;
  assign busy                 = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_xfer_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xfer_scheduler
//  Description : Directed self-checking bench for xfer_scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_xfer_scheduler;

  logic         clock_fpga = 1'b0;
  logic         reset = 1'b0;
  logic         sq_select = 1'b0;
  logic [255:0] cmd_out = '0;
  logic [7:0]   sq_index = '0;
  logic         xfer_complete = 1'b0;
  logic         sq_ack, xfer_buf_select, mwrite_enable, status_update_enable, busy;
  logic [31:0]  tbm_address;
  logic [7:0]   cmdq_index;
  logic [1:0]   status_code;

  int total = 0;
  int bad = 0;

  int n_ack, n_xfer, n_inprog, n_final, mwe_bad, max_run;
  int cyc_ack, cyc_first, cyc_stat;
  logic [1:0]  fin_code;
  logic [7:0]  fin_idx;
  logic [31:0] addr_log [0:15];
  logic [31:0] last_addr;
  bit          timed_out;

  xfer_scheduler #(
    .BLOCK_SHIFT(12), .MAX_BLOCKS(256), .TIMEOUT(4096), .ADDR_W(32)
  ) dut (
    .clock_fpga(clock_fpga), .reset(reset), .sq_select(sq_select),
    .cmd_out(cmd_out), .sq_index(sq_index), .sq_ack(sq_ack),
    .xfer_buf_select(xfer_buf_select), .mwrite_enable(mwrite_enable),
    .tbm_address(tbm_address), .xfer_complete(xfer_complete),
    .status_update_enable(status_update_enable), .cmdq_index(cmdq_index),
    .status_code(status_code), .busy(busy)
  );

  always #5 clock_fpga = ~clock_fpga;

  // Present one CDB, answer each block after lat cycles (or never), and log
  // everything seen at the negative edge until the final status strobe.
  task automatic run_cmd(input logic [7:0] op, input logic [31:0] lba,
                         input logic [15:0] blks, input logic [7:0] slot,
                         input int lat, input bit withhold, input int abort_at);
    int run, wcnt;
    bit done, prev_xbs;
    n_ack = 0; n_xfer = 0; n_inprog = 0; n_final = 0; mwe_bad = 0; max_run = 0;
    cyc_ack = -1; cyc_first = -1; cyc_stat = -1; fin_code = 2'b00; fin_idx = 8'h00;
    last_addr = 32'h0; timed_out = 0;
    for (int i = 0; i < 16; i++) addr_log[i] = 32'hDEAD_BEEF;
    cmd_out = '0;
    cmd_out[7:0] = op;
    cmd_out[63:32] = lba;
    cmd_out[111:96] = blks;
    cmd_out[127:120] = 8'hA5;
    sq_index = slot;
    sq_select = 1'b1;
    run = 0; wcnt = 0; done = 0; prev_xbs = 0;
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      @(posedge clock_fpga);
      @(negedge clock_fpga);
      if (sq_ack) begin
        n_ack++;
        cyc_ack = cyc;
        sq_select = 1'b0;
      end
      if (xfer_buf_select) begin
        if (!prev_xbs) begin
          if (n_xfer < 16) addr_log[n_xfer] = tbm_address;
          if (n_xfer == 0) cyc_first = cyc;
          last_addr = tbm_address;
          n_xfer++;
          run = 0;
          wcnt = 0;
        end
        run++;
        if (run > max_run) max_run = run;
        if (mwrite_enable !== (op == 8'h40)) mwe_bad++;
        wcnt++;
        xfer_complete = (!withhold && wcnt == lat);
        if (abort_at != 0 && n_xfer == abort_at) begin
          xfer_complete = 1'b0;
          #2 reset = 1'b0;
          done = 1;
        end
      end else begin
        xfer_complete = 1'b0;
      end
      if (!done && status_update_enable) begin
        if (status_code == 2'b01) n_inprog++;
        else begin
          n_final++;
          fin_code = status_code;
          fin_idx = cmdq_index;
          cyc_stat = cyc;
          done = 1;
        end
      end
      prev_xbs = xfer_buf_select;
    end
    sq_select = 1'b0;
    if (!done) timed_out = 1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock_fpga);
    total++; if ({sq_ack, xfer_buf_select, mwrite_enable, status_update_enable, busy} !== 5'b0) begin bad++; $display("FAIL reset_ctrl got=%b want=00000", {sq_ack, xfer_buf_select, mwrite_enable, status_update_enable, busy}); end
    total++; if ({tbm_address, cmdq_index, status_code} !== 42'h0) begin bad++; $display("FAIL reset_data got=%h want=0", {tbm_address, cmdq_index, status_code}); end
    reset = 1'b1;
    @(negedge clock_fpga);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_write8();
    run_cmd(8'h40, 32'd0, 16'd8, 8'h17, 2, 0, 0);
    total++; if (timed_out) begin bad++; $display("FAIL w8_timeout got=1 want=0"); end
    total++; if (n_ack !== 1) begin bad++; $display("FAIL w8_acks got=%0d want=1", n_ack); end
    total++; if (n_xfer !== 8) begin bad++; $display("FAIL w8_xfers got=%0d want=8", n_xfer); end
    for (int i = 0; i < 8; i++) begin
      total++; if (addr_log[i] !== 32'(i) * 32'h1000) begin bad++; $display("FAIL w8_addr%0d got=%h want=%h", i, addr_log[i], 32'(i) * 32'h1000); end
    end
    total++; if (mwe_bad !== 0) begin bad++; $display("FAIL w8_mwe got=%0d bad cycles want=0", mwe_bad); end
    total++; if (n_inprog !== 1) begin bad++; $display("FAIL w8_inprog got=%0d want=1", n_inprog); end
    total++; if (cyc_first - cyc_ack !== 3) begin bad++; $display("FAIL w8_latency got=%0d want=3", cyc_first - cyc_ack); end
    total++; if ({fin_code, fin_idx} !== {2'b11, 8'h17}) begin bad++; $display("FAIL w8_status got=%b/%h want=11/17", fin_code, fin_idx); end
    repeat (3) @(negedge clock_fpga);
    total++; if ({status_code, busy} !== {2'b11, 1'b0}) begin bad++; $display("FAIL w8_hold got=%b/%b want=11/0", status_code, busy); end
  endtask

  task automatic test_read2();
    run_cmd(8'h30, 32'd5, 16'd2, 8'h42, 3, 0, 0);
    total++; if (n_xfer !== 2) begin bad++; $display("FAIL r2_xfers got=%0d want=2", n_xfer); end
    total++; if ({addr_log[0], addr_log[1]} !== {32'h5000, 32'h6000}) begin bad++; $display("FAIL r2_addr got=%h,%h want=5000,6000", addr_log[0], addr_log[1]); end
    total++; if (mwe_bad !== 0) begin bad++; $display("FAIL r2_mwe got=%0d bad cycles want=0", mwe_bad); end
    total++; if ({fin_code, fin_idx} !== {2'b11, 8'h42}) begin bad++; $display("FAIL r2_status got=%b/%h want=11/42", fin_code, fin_idx); end
  endtask

  task automatic test_errors();
    int extra;
    run_cmd(8'h55, 32'd0, 16'd4, 8'h09, 1, 0, 0);
    total++; if (n_xfer !== 0 || n_inprog !== 0) begin bad++; $display("FAIL badop_xfer got=%0d/%0d want=0/0", n_xfer, n_inprog); end
    total++; if ({fin_code, fin_idx} !== {2'b10, 8'h09}) begin bad++; $display("FAIL badop_status got=%b/%h want=10/09", fin_code, fin_idx); end
    total++; if (cyc_stat - cyc_ack !== 2) begin bad++; $display("FAIL badop_delay got=%0d want=2", cyc_stat - cyc_ack); end
    extra = 0;
    repeat (5) begin
      @(negedge clock_fpga);
      if (status_update_enable) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL badop_extra got=%0d want=0", extra); end
    run_cmd(8'h40, 32'd0, 16'd257, 8'h0A, 1, 0, 0);
    total++; if (n_xfer !== 0 || n_inprog !== 0) begin bad++; $display("FAIL big_xfer got=%0d/%0d want=0/0", n_xfer, n_inprog); end
    total++; if ({fin_code, cyc_stat - cyc_ack} !== {2'b10, 32'd2}) begin bad++; $display("FAIL big_status got=%b/%0d want=10/2", fin_code, cyc_stat - cyc_ack); end
  endtask

  task automatic test_boundaries();
    run_cmd(8'h40, 32'd0, 16'd0, 8'h33, 1, 0, 0);
    total++; if (n_xfer !== 0 || n_inprog !== 0) begin bad++; $display("FAIL zero_xfer got=%0d/%0d want=0/0", n_xfer, n_inprog); end
    total++; if ({fin_code, fin_idx} !== {2'b11, 8'h33}) begin bad++; $display("FAIL zero_status got=%b/%h want=11/33", fin_code, fin_idx); end
    run_cmd(8'h30, 32'd0, 16'd256, 8'h44, 1, 0, 0);
    total++; if (n_xfer !== 256) begin bad++; $display("FAIL max_xfers got=%0d want=256", n_xfer); end
    total++; if ({last_addr, fin_code} !== {32'h000F_F000, 2'b11}) begin bad++; $display("FAIL max_end got=%h/%b want=000ff000/11", last_addr, fin_code); end
    run_cmd(8'h40, 32'h000F_FFFF, 16'd2, 8'h55, 1, 0, 0);
    total++; if ({addr_log[0], addr_log[1]} !== {32'hFFFF_F000, 32'h0}) begin bad++; $display("FAIL wrap_addr got=%h,%h want=fffff000,00000000", addr_log[0], addr_log[1]); end
    total++; if (fin_code !== 2'b11) begin bad++; $display("FAIL wrap_status got=%b want=11", fin_code); end
  endtask

  task automatic test_timeout();
    run_cmd(8'h40, 32'd1, 16'd3, 8'h66, 1, 1, 0);
    total++; if (max_run !== 4096) begin bad++; $display("FAIL tmo_len got=%0d want=4096", max_run); end
    total++; if ({n_xfer, fin_code, fin_idx} !== {32'd1, 2'b10, 8'h66}) begin bad++; $display("FAIL tmo_status got=%0d/%b/%h want=1/10/66", n_xfer, fin_code, fin_idx); end
  endtask

  task automatic test_back_to_back();
    run_cmd(8'h30, 32'd7, 16'd1, 8'h77, 2, 0, 0);
    total++; if ({n_ack, n_xfer, addr_log[0]} !== {32'd1, 32'd1, 32'h7000}) begin bad++; $display("FAIL b2b_xfer got=%0d/%0d/%h want=1/1/7000", n_ack, n_xfer, addr_log[0]); end
    total++; if ({fin_code, fin_idx} !== {2'b11, 8'h77}) begin bad++; $display("FAIL b2b_status got=%b/%h want=11/77", fin_code, fin_idx); end
  endtask

  task automatic test_reset_mid();
    int strobes;
    run_cmd(8'h40, 32'd0, 16'd8, 8'h88, 2, 0, 3);
    #1;
    total++; if ({sq_ack, xfer_buf_select, mwrite_enable, status_update_enable, busy} !== 5'b0) begin bad++; $display("FAIL abort_ctrl got=%b want=00000", {sq_ack, xfer_buf_select, mwrite_enable, status_update_enable, busy}); end
    total++; if ({tbm_address, cmdq_index, status_code} !== 42'h0) begin bad++; $display("FAIL abort_data got=%h want=0", {tbm_address, cmdq_index, status_code}); end
    strobes = n_final;
    repeat (2) begin
      @(negedge clock_fpga);
      if (status_update_enable) strobes++;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock_fpga);
      if (status_update_enable) strobes++;
    end
    total++; if (strobes !== 0) begin bad++; $display("FAIL abort_nostatus got=%0d want=0", strobes); end
    run_cmd(8'h40, 32'd2, 16'd1, 8'h99, 1, 0, 0);
    total++; if ({n_xfer, addr_log[0], fin_code, fin_idx} !== {32'd1, 32'h2000, 2'b11, 8'h99}) begin bad++; $display("FAIL after_abort got=%0d/%h/%b/%h want=1/2000/11/99", n_xfer, addr_log[0], fin_code, fin_idx); end
  endtask

  initial begin
    test_reset();
    test_write8();
    test_read2();
    test_errors();
    test_boundaries();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
